// File: rtl/bram_rd_responder_if.sv
// rtl/bram_rd_responder_if.sv - write port and read request/response handshake bundle
interface bram_rd_responder_if #(
    parameter int ABITS = 8,
    parameter int DBITS = 8
);
    logic [ABITS-1:0] WR_ADDR;
    logic [DBITS-1:0] WR_DATA;
    logic             WR_EN;
    logic [ABITS-1:0] RD_ADDR;
    logic             RD_REQ_VALID;
    logic             RD_REQ_READY;
    logic             RD_RSP_VALID;
    logic             RD_RSP_READY;
    logic [DBITS-1:0] RD_DATA;

    modport master (
        output WR_ADDR, WR_DATA, WR_EN, RD_ADDR, RD_REQ_VALID, RD_RSP_READY,
        input  RD_REQ_READY, RD_RSP_VALID, RD_DATA
    );

    modport slave (
        input  WR_ADDR, WR_DATA, WR_EN, RD_ADDR, RD_REQ_VALID, RD_RSP_READY,
        output RD_REQ_READY, RD_RSP_VALID, RD_DATA
    );
endinterface

// File: rtl/bram_rd_responder.sv
// rtl/bram_rd_responder.sv - simple-dual-port RAM with in-order, credit-limited read responses
module bram_rd_responder #(
    parameter int ABITS  = 8,
    parameter int DBITS  = 8,
    parameter int TRANSP = 0,
    parameter int OUTREG = 0
) (
    input logic                clk,
    input logic                rst,
    bram_rd_responder_if.slave bus
);
    localparam int DEPTH = 1 << ABITS;
    localparam int QD    = 2 + OUTREG;
    localparam int PW    = $clog2(QD);
    localparam int CW    = $clog2(QD) + 1;

    logic [DBITS-1:0] mem [DEPTH];

    logic             accept;
    logic             pop;
    logic             push;
    logic             rdw_hit;
    logic [DBITS-1:0] rd_word;
    logic [DBITS-1:0] push_data;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    qcnt_q, qcnt_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [DBITS-1:0] q_data_q [QD];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QD - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on the registered credit count, never on this cycle's handshakes.
    assign bus.RD_REQ_READY = ~rst & (cnt_q < CW'(QD));
    assign bus.RD_RSP_VALID = (qcnt_q != '0);
    assign bus.RD_DATA      = bus.RD_RSP_VALID ? q_data_q[rptr_q] : '0;

    assign accept = bus.RD_REQ_VALID & bus.RD_REQ_READY;
    assign pop    = bus.RD_RSP_VALID & bus.RD_RSP_READY;

    assign rdw_hit = (TRANSP != 0) && bus.WR_EN && (bus.WR_ADDR == bus.RD_ADDR);
    assign rd_word = rdw_hit ? bus.WR_DATA : mem[bus.RD_ADDR];

    always_ff @(posedge clk) begin
        if (!rst && bus.WR_EN) begin
            mem[bus.WR_ADDR] <= bus.WR_DATA;
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic             s1_vld_q;
            logic [DBITS-1:0] s1_data_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_vld_q  <= 1'b0;
                    s1_data_q <= '0;
                end else begin
                    s1_vld_q <= accept;
                    if (accept) begin
                        s1_data_q <= rd_word;
                    end
                end
            end

            assign push      = s1_vld_q;
            assign push_data = s1_data_q;
        end else begin : g_direct
            assign push      = accept;
            assign push_data = rd_word;
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        qcnt_d = qcnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({push, pop})
            2'b10:   qcnt_d = qcnt_q + CW'(1);
            2'b01:   qcnt_d = qcnt_q - CW'(1);
            default: qcnt_d = qcnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            qcnt_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            qcnt_q <= qcnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Credits bound in-flight plus queued reads to QD, so a push never lands on a full queue.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data_q[wptr_q] <= push_data;
        end
    end
endmodule

// File: tb/tb_bram_rd_responder.sv
// tb/tb_bram_rd_responder.sv - scoreboard bench over all TRANSP/OUTREG combinations
module tb_bram_rd_responder;
    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req_valid;
    logic [7:0] rd_addr;
    logic       rsp_ready;

    logic [3:0] req_ready_w;
    logic [3:0] rsp_valid_w;
    logic [7:0] rd_data_w [4];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mdata  [256];
    bit         mknown [256];
    logic [8:0] eq0[$], eq1[$], eq2[$], eq3[$];
    int         acc_cnt [4];
    bit         stall_q [4];
    logic [7:0] held_q  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int TR = g % 2;
        localparam int OR = g / 2;
        localparam int DD = 2 + OR;

        bram_rd_responder_if #(.ABITS(8), .DBITS(8)) bus ();

        assign bus.WR_ADDR      = wr_addr;
        assign bus.WR_DATA      = wr_data;
        assign bus.WR_EN        = wr_en;
        assign bus.RD_ADDR      = rd_addr;
        assign bus.RD_REQ_VALID = rd_req_valid;
        assign bus.RD_RSP_READY = rsp_ready;
        assign req_ready_w[g]   = bus.RD_REQ_READY;
        assign rsp_valid_w[g]   = bus.RD_RSP_VALID;
        assign rd_data_w[g]     = bus.RD_DATA;

        bram_rd_responder #(.ABITS(8), .DBITS(8), .TRANSP(TR), .OUTREG(OR)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        always @(negedge clk) begin
            if (!rst) begin
                n_cmp++;
                if (u_dut.cnt_q > DD) begin
                    n_fail++;
                    $display("FAIL cnt_bound[g%0d]: got %0d expected <= %0d", g, u_dut.cnt_q, DD);
                end
            end
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[g%0d]: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    task automatic push_exp(input int g, input logic [8:0] v);
        case (g)
            0:       eq0.push_back(v);
            1:       eq1.push_back(v);
            2:       eq2.push_back(v);
            default: eq3.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int g, output logic [8:0] v, output bit ok);
        ok = 1'b1;
        v  = '0;
        case (g)
            0:       if (eq0.size() > 0) v = eq0.pop_front(); else ok = 1'b0;
            1:       if (eq1.size() > 0) v = eq1.pop_front(); else ok = 1'b0;
            2:       if (eq2.size() > 0) v = eq2.pop_front(); else ok = 1'b0;
            default: if (eq3.size() > 0) v = eq3.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int exp_size(input int g);
        case (g)
            0:       return eq0.size();
            1:       return eq1.size();
            2:       return eq2.size();
            default: return eq3.size();
        endcase
    endfunction

    task automatic step(input bit wen, input logic [7:0] wa, input logic [7:0] wd,
                        input bit rv, input logic [7:0] ra, input bit rr);
        logic [8:0] v;
        @(negedge clk);
        wr_en        = wen;
        wr_addr      = wa;
        wr_data      = wd;
        rd_req_valid = rv;
        rd_addr      = ra;
        rsp_ready    = rr;
        #1;
        for (int g = 0; g < 4; g++) begin
            if (rv && req_ready_w[g]) begin
                acc_cnt[g]++;
                if (wen && (wa == ra) && (g % 2 == 1)) v = {1'b1, wd};
                else v = {mknown[ra], mdata[ra]};
                push_exp(g, v);
            end
        end
        if (wen) begin
            mdata[wa]  = wd;
            mknown[wa] = 1'b1;
        end
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, rr);
    endtask

    always begin
        logic [8:0] v;
        bit         ok;
        @(negedge clk);
        #2;
        for (int g = 0; g < 4; g++) begin
            if (stall_q[g]) begin
                chk("hold_valid", g, 32'(rsp_valid_w[g]), 32'd1);
                chk("hold_data", g, 32'(rd_data_w[g]), 32'(held_q[g]));
            end
            if (rsp_valid_w[g] && rsp_ready) begin
                pop_exp(g, v, ok);
                if (!ok) chk("unexpected_rsp", g, 32'(rd_data_w[g]), 32'hFFFF_FFFF);
                else if (v[8]) chk("rsp_data", g, 32'(rd_data_w[g]), 32'(v[7:0]));
            end
            stall_q[g] = rsp_valid_w[g] && !rsp_ready;
            held_q[g]  = rd_data_w[g];
        end
    end

    initial begin
        logic [63:0] rs;
        rs = 64'h9E37_79B9_7F4A_7C15;
        for (int i = 0; i < 256; i++) begin
            mknown[i] = 1'b0;
            mdata[i]  = 8'h00;
        end
        for (int g = 0; g < 4; g++) begin
            acc_cnt[g] = 0;
            stall_q[g] = 1'b0;
            held_q[g]  = 8'h00;
        end
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req_valid = 1'b0; rd_addr = '0; rsp_ready = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("reset_rsp_valid", g, 32'(rsp_valid_w[g]), 32'd0);
            chk("reset_rd_data", g, 32'(rd_data_w[g]), 32'd0);
            chk("reset_req_ready", g, 32'(req_ready_w[g]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Basic write then read-back, with response latency L = 1 + OUTREG.
        step(1'b1, 8'h12, 8'hA5, 1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h12, 1'b0);
        idle(1'b0);
        for (int g = 0; g < 4; g++) chk("lat_first", g, 32'(rsp_valid_w[g]), 32'(g / 2 == 0));
        idle(1'b0);
        for (int g = 0; g < 4; g++) chk("lat_second", g, 32'(rsp_valid_w[g]), 32'd1);
        idle(1'b1);
        idle(1'b1);

        // Read-during-write on the same address.
        step(1'b1, 8'h34, 8'h11, 1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h34, 8'h22, 1'b1, 8'h34, 1'b1);
        repeat (3) idle(1'b1);

        // Backpressure: exactly D reads accepted while responses are held.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 8'h00, 1'b0);
        for (int g = 0; g < 4; g++) acc_cnt[g] = 0;
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 8'h00, 1'b1, 8'(i), 1'b0);
        for (int g = 0; g < 4; g++) begin
            chk("acc_cnt_full", g, 32'(acc_cnt[g]), 32'(2 + g / 2));
            chk("req_ready_full", g, 32'(req_ready_w[g]), 32'd0);
        end
        repeat (5) idle(1'b1);

        // Full throughput: one accept and one response per cycle after latency L.
        for (int k = 0; k < 18; k++) begin
            step(1'b0, 8'h00, 8'h00, k < 16, 8'(k), 1'b1);
            for (int g = 0; g < 4; g++) begin
                if (k < 16) chk("tput_ready", g, 32'(req_ready_w[g]), 32'd1);
                if (k >= 1) chk("tput_valid", g, 32'(rsp_valid_w[g]),
                                32'((k >= 1 + g / 2) && (k <= 16 + g / 2)));
            end
        end
        repeat (2) idle(1'b1);

        // Reset with two responses queued.
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0);
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);
        idle(1'b0);
        idle(1'b0);
        #2;
        rst = 1'b1;
        eq0.delete(); eq1.delete(); eq2.delete(); eq3.delete();
        for (int g = 0; g < 4; g++) stall_q[g] = 1'b0;
        #1;
        for (int g = 0; g < 4; g++) begin
            chk("midrst_rsp_valid", g, 32'(rsp_valid_w[g]), 32'd0);
            chk("midrst_rd_data", g, 32'(rd_data_w[g]), 32'd0);
            chk("midrst_req_ready", g, 32'(req_ready_w[g]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            for (int g = 0; g < 4; g++) chk("no_stale", g, 32'(rsp_valid_w[g]), 32'd0);
        end
        step(1'b0, 8'h00, 8'h00, 1'b1, 8'h12, 1'b1);
        repeat (3) idle(1'b1);

        // Random traffic against the behavioural model.
        for (int i = 0; i < 512; i++) begin
            rs = rs ^ (rs << 13);
            rs = rs ^ (rs >> 7);
            rs = rs ^ (rs << 17);
            step(rs[0], {4'h0, rs[7:4]}, rs[15:8], rs[16] | rs[17],
                 {4'h0, rs[23:20]}, rs[24] | rs[25]);
        end
        repeat (8) idle(1'b1);
        for (int g = 0; g < 4; g++) chk("drained", g, 32'(exp_size(g)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
